// File: rtl/spi_adc_pkg.sv
// Shared definitions for the SPI ADC command controller: command codes,
// frame FSM encoding, readback length and the readback byte mux.
package spi_adc_pkg;

   localparam logic [7:0] CMD_SNAPSHOT = 8'h01;
   localparam logic [7:0] CMD_READ     = 8'h02;
   localparam logic [7:0] CMD_STATUS   = 8'h03;
   localparam logic [7:0] CMD_WRDECIM  = 8'h10;

   // Number of bytes returned by a READ frame
   localparam int READ_LEN = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_READ,
      ST_WARG,
      ST_DRAIN
   } state_e;

   // Snapshot readback order: ch1 hi/lo, ch2 hi/lo, seq hi/lo
   function automatic logic [7:0] read_byte(input logic [2:0]  idx,
                                            input logic [11:0] ch1,
                                            input logic [11:0] ch2,
                                            input logic [15:0] seq);
      logic [7:0] b;
      case (idx)
         3'd0:    b = {4'b0, ch1[11:8]};
         3'd1:    b = ch1[7:0];
         3'd2:    b = {4'b0, ch2[11:8]};
         3'd3:    b = ch2[7:0];
         3'd4:    b = seq[15:8];
         3'd5:    b = seq[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/spi_adc_cmd_ctrl_if.sv
// Byte-level SPI driver link plus the ADC sample stream feeding the
// command controller. master = driver/ADC side, slave = controller.
interface spi_adc_cmd_ctrl_if;
   logic [7:0]  rec_data;
   logic        rec_done;
   logic [7:0]  response_data;
   logic        smp_valid;
   logic [11:0] smp_ch1;
   logic [11:0] smp_ch2;

   modport master (
      output rec_data, rec_done, smp_valid, smp_ch1, smp_ch2,
      input  response_data
   );

   modport slave (
      input  rec_data, rec_done, smp_valid, smp_ch1, smp_ch2,
      output response_data
   );
endinterface

// File: rtl/spi_adc_cmd_ctrl_cs_sync.sv
// Chip-select synchroniser with edge pulses. Edges are suppressed for the
// first few cycles after reset so that a reset released while cs_n is
// already low is not mistaken for the start of a new frame.
module cs_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic cs_n,
   output logic frame_active,
   output logic cs_fall,
   output logic cs_rise
);

   logic       s1_q, s1_d;
   logic       s2_q, s2_d;
   logic       prev_q, prev_d;
   logic [2:0] warm_q, warm_d;

   // Next-state for the synchroniser chain and warm-up shift register
   always_comb begin
      s1_d   = cs_n;
      s2_d   = s1_q;
      prev_d = s2_q;
      warm_d = {warm_q[1:0], 1'b1};
   end

   // Flops reset to the deasserted (high) chip-select level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
         prev_q <= 1'b1;
         warm_q <= '0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
         warm_q <= warm_d;
      end
   end

   assign frame_active = ~s2_q;
   assign cs_fall      = warm_q[2] &  prev_q & ~s2_q;
   assign cs_rise      = warm_q[2] & ~prev_q &  s2_q;

endmodule

// File: rtl/spi_adc_cmd_ctrl.sv
// Command controller between the SPI slave byte driver and the dual 12-bit
// ADC capture path: sample decimation, snapshot capture and readback.
module spi_adc_cmd_ctrl
   import spi_adc_pkg::*;
#(
   parameter logic [7:0] DECIM_RST = 8'd0,
   parameter logic [7:0] ACK_BYTE  = 8'hA5,
   parameter logic [7:0] ERR_BYTE  = 8'hEE
) (
   input  logic               sys_clk,
   input  logic               rst_n,
   input  logic               cs_n,
   spi_adc_cmd_ctrl_if.slave  bus,
   output logic               frame_active,
   output logic               snap_valid
);

   logic cs_fall, cs_rise;

   // Live path
   logic [7:0]  dcnt_q, dcnt_d;
   logic [7:0]  decim_q, decim_d;
   logic [11:0] live_ch1_q, live_ch1_d;
   logic [11:0] live_ch2_q, live_ch2_d;
   logic [15:0] seq_q, seq_d;
   logic        decim_wr;

   // Frame / snapshot path
   state_e      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  resp_q, resp_d;
   logic [11:0] snap_ch1_q, snap_ch1_d;
   logic [11:0] snap_ch2_q, snap_ch2_d;
   logic [15:0] snap_seq_q, snap_seq_d;
   logic        snap_valid_q, snap_valid_d;
   logic        overrun_q, overrun_d;

   cs_sync u_cs_sync (
      .clk          (sys_clk),
      .rst_n        (rst_n),
      .cs_n         (cs_n),
      .frame_active (frame_active),
      .cs_fall      (cs_fall),
      .cs_rise      (cs_rise)
   );

   // Decimate incoming samples into the live registers; a decim write
   // restarts the decimation count
   always_comb begin
      dcnt_d     = dcnt_q;
      live_ch1_d = live_ch1_q;
      live_ch2_d = live_ch2_q;
      seq_d      = seq_q;
      if (bus.smp_valid) begin
         if (dcnt_q == decim_q) begin
            live_ch1_d = bus.smp_ch1;
            live_ch2_d = bus.smp_ch2;
            seq_d      = seq_q + 16'd1;
            dcnt_d     = '0;
         end else begin
            dcnt_d = dcnt_q + 8'd1;
         end
      end
      if (decim_wr)
         dcnt_d = '0;
   end

   // Frame FSM: command decode, readback sequencing and response byte.
   // Snapshot reads the live *_q registers, so a same-cycle live update
   // is not seen by the capture.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      resp_d       = resp_q;
      snap_ch1_d   = snap_ch1_q;
      snap_ch2_d   = snap_ch2_q;
      snap_seq_d   = snap_seq_q;
      snap_valid_d = snap_valid_q;
      overrun_d    = overrun_q;
      decim_d      = decim_q;
      decim_wr     = 1'b0;

      if (cs_rise) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_d = ST_CMD;
                  resp_d  = 8'h00;
               end
            end
            ST_CMD: begin
               if (bus.rec_done) begin
                  case (bus.rec_data)
                     CMD_SNAPSHOT: begin
                        snap_ch1_d   = live_ch1_q;
                        snap_ch2_d   = live_ch2_q;
                        snap_seq_d   = seq_q;
                        if (snap_valid_q)
                           overrun_d = 1'b1;
                        snap_valid_d = 1'b1;
                        resp_d       = ACK_BYTE;
                        state_d      = ST_DRAIN;
                     end
                     CMD_READ: begin
                        resp_d  = read_byte(3'd0, snap_ch1_q, snap_ch2_q, snap_seq_q);
                        idx_d   = 3'd1;
                        state_d = ST_READ;
                     end
                     CMD_STATUS: begin
                        resp_d    = {6'b0, overrun_q, snap_valid_q};
                        overrun_d = 1'b0;
                        state_d   = ST_DRAIN;
                     end
                     CMD_WRDECIM: begin
                        resp_d  = decim_q;
                        state_d = ST_WARG;
                     end
                     default: begin
                        resp_d  = ERR_BYTE;
                        state_d = ST_DRAIN;
                     end
                  endcase
               end
            end
            ST_READ: begin
               if (bus.rec_done) begin
                  if (idx_q < 3'(READ_LEN)) begin
                     resp_d = read_byte(idx_q, snap_ch1_q, snap_ch2_q, snap_seq_q);
                     idx_d  = idx_q + 3'd1;
                  end else begin
                     snap_valid_d = 1'b0;
                     resp_d       = 8'h00;
                     state_d      = ST_DRAIN;
                  end
               end
            end
            ST_WARG: begin
               if (bus.rec_done) begin
                  decim_d  = bus.rec_data;
                  decim_wr = 1'b1;
                  resp_d   = ACK_BYTE;
                  state_d  = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (bus.rec_done)
                  resp_d = 8'h00;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State registers for both paths
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt_q       <= '0;
         decim_q      <= DECIM_RST;
         live_ch1_q   <= '0;
         live_ch2_q   <= '0;
         seq_q        <= '0;
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         resp_q       <= 8'h00;
         snap_ch1_q   <= '0;
         snap_ch2_q   <= '0;
         snap_seq_q   <= '0;
         snap_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         dcnt_q       <= dcnt_d;
         decim_q      <= decim_d;
         live_ch1_q   <= live_ch1_d;
         live_ch2_q   <= live_ch2_d;
         seq_q        <= seq_d;
         state_q      <= state_d;
         idx_q        <= idx_d;
         resp_q       <= resp_d;
         snap_ch1_q   <= snap_ch1_d;
         snap_ch2_q   <= snap_ch2_d;
         snap_seq_q   <= snap_seq_d;
         snap_valid_q <= snap_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus.response_data = resp_q;
   assign snap_valid        = snap_valid_q;

endmodule

// File: tb/tb_spi_adc_cmd_ctrl.sv
// Directed bench for spi_adc_cmd_ctrl: a table of SPI frames with
// hand-computed response bytes, plus sequences for IDLE strobes, seq wrap
// and reset in the middle of a frame.
module tb_spi_adc_cmd_ctrl;

   logic sys_clk = 1'b0;
   logic rst_n;
   logic cs_n;
   logic frame_active;
   logic snap_valid;

   int total = 0;
   int bad   = 0;

   spi_adc_cmd_ctrl_if ifc ();

   spi_adc_cmd_ctrl #(
      .DECIM_RST (8'd0),
      .ACK_BYTE  (8'hA5),
      .ERR_BYTE  (8'hEE)
   ) dut (
      .sys_clk      (sys_clk),
      .rst_n        (rst_n),
      .cs_n         (cs_n),
      .bus          (ifc),
      .frame_active (frame_active),
      .snap_valid   (snap_valid)
   );

   always #5 sys_clk = ~sys_clk;

   // One frame: optional samples beforehand, then n bytes. tx/rx hold byte 0
   // in the top 8 bits. rx is the response_data expected after each byte.
   typedef struct {
      int          nsmp;
      logic [11:0] c1;
      logic [11:0] c2;
      bit          smp_cmd;   // fire a sample in the same cycle as byte 0
      int          n;
      logic [63:0] tx;
      logic [63:0] rx;
      logic        snap;      // snap_valid expected after the frame
   } vec_t;

   function automatic vec_t mk(int nsmp, logic [11:0] c1, logic [11:0] c2, bit sc,
                               int n, logic [63:0] tx, logic [63:0] rx, logic snap);
      vec_t v;
      v.nsmp = nsmp; v.c1 = c1; v.c2 = c2; v.smp_cmd = sc;
      v.n = n; v.tx = tx; v.rx = rx; v.snap = snap;
      return v;
   endfunction

   function automatic logic [7:0] byte_at(logic [63:0] w, int i);
      return w[63-8*i -: 8];
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // All tasks start and end just after a falling clock edge
   task automatic samples(input int n, input logic [11:0] a, input logic [11:0] b);
      if (n > 0) begin
         ifc.smp_valid = 1'b1;
         ifc.smp_ch1   = a;
         ifc.smp_ch2   = b;
         repeat (n) @(negedge sys_clk);
         ifc.smp_valid = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit with_smp,
                            input logic [11:0] a, input logic [11:0] c,
                            output logic [7:0] r);
      ifc.rec_data = b;
      ifc.rec_done = 1'b1;
      if (with_smp) begin
         ifc.smp_valid = 1'b1;
         ifc.smp_ch1   = a;
         ifc.smp_ch2   = c;
      end
      @(negedge sys_clk);
      ifc.rec_done  = 1'b0;
      ifc.smp_valid = 1'b0;
      r = ifc.response_data;
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic apply_vec(input vec_t v, input string nm);
      logic [7:0] r;
      samples(v.nsmp, v.c1, v.c2);
      cs_n = 1'b0;
      repeat (4) @(negedge sys_clk);
      check({nm, ".fa1"}, 32'(frame_active), 32'd1);
      for (int i = 0; i < v.n; i++) begin
         send_byte(byte_at(v.tx, i), v.smp_cmd && (i == 0), v.c1, v.c2, r);
         check($sformatf("%s.b%0d", nm, i), 32'(r), 32'(byte_at(v.rx, i)));
      end
      cs_n = 1'b1;
      repeat (4) @(negedge sys_clk);
      check({nm, ".fa0"}, 32'(frame_active), 32'd0);
      check({nm, ".snap"}, 32'(snap_valid), 32'(v.snap));
   endtask

   vec_t vt[17];

   initial begin
      logic [7:0] r;

      // seq/decim history: decim 0 -> 1 sample (seq 1); decim 3 -> 8 samples
      // (seq 3); decim 0 -> same-cycle sample (seq 4)
      vt[0]  = mk(1, 12'hABC, 12'h123, 0, 1, 64'h01FF_FFFF_FFFF_FFFF, 64'hA500_0000_0000_0000, 1);
      vt[1]  = mk(0, 0, 0, 0, 7, 64'h02FF_FFFF_FFFF_FFFF, 64'h0ABC_0123_0001_0000, 0);
      vt[2]  = mk(0, 0, 0, 0, 2, 64'h1003_0000_0000_0000, 64'h00A5_0000_0000_0000, 0);
      vt[3]  = mk(8, 12'h456, 12'h789, 0, 1, 64'h0100_0000_0000_0000, 64'hA500_0000_0000_0000, 1);
      vt[4]  = mk(0, 0, 0, 0, 1, 64'h0100_0000_0000_0000, 64'hA500_0000_0000_0000, 1);
      vt[5]  = mk(0, 0, 0, 0, 2, 64'h03FF_0000_0000_0000, 64'h0300_0000_0000_0000, 1);
      vt[6]  = mk(0, 0, 0, 0, 2, 64'h03FF_0000_0000_0000, 64'h0100_0000_0000_0000, 1);
      vt[7]  = mk(0, 0, 0, 0, 3, 64'h7FFF_FF00_0000_0000, 64'hEE00_0000_0000_0000, 1);
      vt[8]  = mk(0, 0, 0, 0, 3, 64'h02FF_FF00_0000_0000, 64'h0456_0700_0000_0000, 1);
      vt[9]  = mk(0, 0, 0, 0, 7, 64'h02FF_FFFF_FFFF_FFFF, 64'h0456_0789_0003_0000, 0);
      vt[10] = mk(0, 0, 0, 0, 1, 64'h1000_0000_0000_0000, 64'h0300_0000_0000_0000, 0);
      vt[11] = mk(0, 0, 0, 0, 2, 64'h1000_0000_0000_0000, 64'h03A5_0000_0000_0000, 0);
      vt[12] = mk(0, 12'hDEF, 12'h321, 1, 1, 64'h0100_0000_0000_0000, 64'hA500_0000_0000_0000, 1);
      vt[13] = mk(0, 0, 0, 0, 6, 64'h02FF_FFFF_FFFF_0000, 64'h0456_0789_0003_0000, 1);
      vt[14] = mk(0, 0, 0, 0, 1, 64'h0100_0000_0000_0000, 64'hA500_0000_0000_0000, 1);
      vt[15] = mk(0, 0, 0, 0, 7, 64'h02FF_FFFF_FFFF_FFFF, 64'h0DEF_0321_0004_0000, 0);
      vt[16] = mk(0, 0, 0, 0, 2, 64'h03FF_0000_0000_0000, 64'h0200_0000_0000_0000, 0);

      rst_n = 1'b0;
      cs_n  = 1'b1;
      ifc.rec_data  = '0;
      ifc.rec_done  = 1'b0;
      ifc.smp_valid = 1'b0;
      ifc.smp_ch1   = '0;
      ifc.smp_ch2   = '0;
      repeat (3) @(negedge sys_clk);
      check("rst.resp", 32'(ifc.response_data), 32'h00);
      check("rst.fa",   32'(frame_active), 32'd0);
      check("rst.snap", 32'(snap_valid), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);

      for (int i = 0; i < 17; i++)
         apply_vec(vt[i], $sformatf("v%0d", i));

      // rec_done with cs_n high must not decode anything
      send_byte(8'h01, 0, 0, 0, r);
      check("idle.resp", 32'(r), 32'h00);
      check("idle.snap", 32'(snap_valid), 32'd0);

      // seq is 4 with decim 0: 65531 updates reach 0xFFFF, one more wraps
      samples(65531, 12'h111, 12'h222);
      apply_vec(mk(0, 0, 0, 0, 1, 64'h0100_0000_0000_0000, 64'hA500_0000_0000_0000, 1), "wrap0s");
      apply_vec(mk(0, 0, 0, 0, 7, 64'h02FF_FFFF_FFFF_FFFF, 64'h0111_0222_FFFF_0000, 0), "wrap0r");
      samples(1, 12'h333, 12'h444);
      apply_vec(mk(0, 0, 0, 0, 1, 64'h0100_0000_0000_0000, 64'hA500_0000_0000_0000, 1), "wrap1s");
      apply_vec(mk(0, 0, 0, 0, 7, 64'h02FF_FFFF_FFFF_FFFF, 64'h0333_0444_0000_0000, 0), "wrap1r");

      // Reset in the middle of a WRDECIM frame
      apply_vec(mk(0, 0, 0, 0, 2, 64'h1007_0000_0000_0000, 64'h00A5_0000_0000_0000, 0), "dec7");
      cs_n = 1'b0;
      repeat (4) @(negedge sys_clk);
      send_byte(8'h10, 0, 0, 0, r);
      check("mid.cmd", 32'(r), 32'h07);
      rst_n = 1'b0;
      @(negedge sys_clk);
      check("mid.rst.resp", 32'(ifc.response_data), 32'h00);
      check("mid.rst.fa",   32'(frame_active), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);
      check("mid.fa", 32'(frame_active), 32'd1);
      send_byte(8'h05, 0, 0, 0, r);
      check("mid.ign", 32'(r), 32'h00);
      send_byte(8'h01, 0, 0, 0, r);
      check("mid.ign2", 32'(r), 32'h00);
      check("mid.snap", 32'(snap_valid), 32'd0);
      cs_n = 1'b1;
      repeat (4) @(negedge sys_clk);
      apply_vec(mk(0, 0, 0, 0, 2, 64'h1000_0000_0000_0000, 64'h00A5_0000_0000_0000, 0), "post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_adc_cmd_ctrl.md
# spi_adc_cmd_ctrl

Command controller between the byte-level SPI slave driver and the dual 12-bit ADC capture path. It decodes host command frames from `rec_data`/`rec_done` and sequences ADC sample decimation, snapshot capture and readback. It drives `response_data` so the driver shifts the correct byte on each following SPI transfer. It sits in the `sys_clk` domain alongside the SPI slave driver, downstream of the ADC sample synchroniser.

## Interface
Parameters:
- `DECIM_RST`, default 8'd0: reset value of the decimation register (0 = keep every sample).
- `ACK_BYTE`, default 8'hA5: acknowledge byte returned after accepted actions.
- `ERR_BYTE`, default 8'hEE: byte returned after an unknown command.

Ports:
- `sys_clk`  in  1: single clock; everything is in this domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cs_n`  in  1: raw SPI chip select; synchronised internally by a 2-FF synchroniser.
- `rec_data`  in  8: byte received from the SPI driver.
- `rec_done`  in  1: one-cycle strobe; `rec_data` is valid in the same cycle.
- `response_data`  out  8: byte the driver shifts out on the next transfer.
- `smp_valid`  in  1: one-cycle ADC sample strobe, already in the `sys_clk` domain.
- `smp_ch1`, `smp_ch2`  in  12 each: ADC samples, valid with `smp_valid`.
- `frame_active`  out  1: synchronised, inverted `cs_n`.
- `snap_valid`  out  1: a snapshot is held and has not been fully read.

## Operation
Live path:
- Decimation counter `dcnt` (8 bit) increments on each `smp_valid`.
- When `dcnt == decim`: load live registers `live_ch1`/`live_ch2` with the sample, increment 16-bit `seq` (wraps 0xFFFF→0x0000), and clear `dcnt`.

Frame FSM states: IDLE, CMD, READ, WARG, DRAIN.
- IDLE → CMD on synchronised `cs_n` falling. `response_data` = 0x00.
- In CMD, the first `rec_done` decodes `rec_data`:
  - 0x01 SNAPSHOT: copy live ch1/ch2/seq into the snapshot registers. If `snap_valid` is already 1, set sticky `overrun`. Set `snap_valid`. `response_data`←`ACK_BYTE`. Go to DRAIN.
  - 0x02 READ: `response_data`←byte 0. Go to READ with index 1.
  - 0x03 STATUS: `response_data`←{6'b0, overrun, snap_valid}. Clear `overrun`. Go to DRAIN.
  - 0x10 WRDECIM: `response_data`←current `decim`. Go to WARG.
  - Any other value: `response_data`←`ERR_BYTE`. Go to DRAIN.
- READ byte order (zero-extended high bytes):
  - byte 0: {4'b0, ch1[11:8]}
  - byte 1: ch1[7:0]
  - byte 2: {4'b0, ch2[11:8]}
  - byte 3: ch2[7:0]
  - byte 4: seq[15:8]
  - byte 5: seq[7:0]
- Each `rec_done` in READ loads the next byte. After byte 5 is loaded, the next `rec_done` clears `snap_valid`, loads 0x00 and moves to DRAIN.
- WARG: the next `rec_done` writes `rec_data` to `decim`, clears `dcnt`, loads `ACK_BYTE`, and moves to DRAIN.
- DRAIN: ignore `rec_data`; each `rec_done` loads 0x00.
- Any state → IDLE on synchronised `cs_n` rising. A frame aborted mid-READ leaves `snap_valid` set. An aborted WARG leaves `decim` unchanged.

## Timing
- `response_data` is registered and updated in the cycle after `rec_done`. The driver requires it stable before the next byte's first SCLK edge, which is guaranteed for `sys_clk` ≥ 4× SCLK.
- `cs_n` edges are seen 2 cycles late. `rec_done` in IDLE is ignored.
- Snapshot in the same cycle as a live update captures the pre-update values.
- Reset values:
  - `response_data` = 0x00, `frame_active` = 0, `snap_valid` = 0
  - `overrun` = 0, `seq` = 0, `live_ch*` = 0, `snap_*` = 0
  - `decim` = `DECIM_RST`, `dcnt` = 0, FSM = IDLE
- Reset mid-frame returns to IDLE immediately. The host's remaining bytes are ignored until the next `cs_n` falling edge.

## Structure
- Shared package `spi_adc_pkg`: command codes (`CMD_SNAPSHOT`, `CMD_READ`, `CMD_STATUS`, `CMD_WRDECIM`), FSM state encoding, and the READ length constant (6).
- One natural sub-module, `cs_sync`: 2-FF synchroniser plus edge detector producing `cs_fall`/`cs_rise` pulses.

## Test plan
- Reset, then `smp_valid` with ch1=0xABC, ch2=0x123. Frame [0x01] → response 0xA5, `snap_valid`=1. Frame [0x02, x×7] → returned bytes 0x0A, 0xBC, 0x01, 0x23, 0x00, 0x01, 0x00; `snap_valid`=0.
- Frame [0x10, 0x03] → returned bytes 0x00 (old `decim`), 0xA5. Then 8 `smp_valid` pulses → `seq` advances by 2 (updates on samples 4 and 8).
- Two SNAPSHOT frames without a READ. Frame [0x03, x] → returns 0x03. A second STATUS frame returns 0x01.
- Frame [0x7F, x, x] → returns 0xEE, 0x00. No register changes.
- `cs_n` raised after READ byte 2 → FSM back to IDLE, `snap_valid` stays 1. A new READ frame restarts at byte 0.
- `seq` preset near wrap: 0xFFFF live update followed by one more → `seq`=0x0000. Snapshot taken in the same cycle as an update returns the old values.
